mem_port_arbiter: RTL

- Shares one single-port synchronous RAM between the core's instruction-fetch port and data port, so the core can run from a single-ported memory macro.
- Arbitrates per cycle, drives the memory command, routes the 1-cycle-latency read data back to the winning requester, and prevents fetch starvation.
- Sits between steel_top and the ram instance in design_top.

---
 rtl/mem_port_arbiter_pkg.sv | 15 +
 rtl/mem_port_arbiter_starve.sv | 51 +++++
 rtl/mem_port_arbiter.sv | 101 ++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the fetch/data single-port RAM arbiter.
package mem_port_arbiter_pkg;

  localparam int unsigned ADDR_W_DEF = 11;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned CNT_W      = 4;

  // Which requester owns the read response returning from the RAM this cycle.
  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_INSTR = 2'd1,
    OWN_DATA  = 2'd2
  } own_e;

endpackage

// File: rtl/mem_port_arbiter_starve.sv
// Saturating fetch-starvation counter and per-cycle I/D priority select.
module arb_starve_ctr
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic i_req_i,
  input  logic d_req_i,
  output logic i_gnt_c_o,
  output logic d_gnt_c_o
);

  logic [CNT_W-1:0] starve_q;
  logic [CNT_W-1:0] starve_d;
  logic             starved_c;

  assign starved_c = (starve_q == CNT_W'(STARVE_MAX));

  // Data side wins conflicts until fetch has lost STARVE_MAX times in a row.
  always_comb begin
    i_gnt_c_o = 1'b0;
    d_gnt_c_o = 1'b0;
    if (rst_ni) begin
      if (i_req_i && (!d_req_i || starved_c)) begin
        i_gnt_c_o = 1'b1;
      end else if (d_req_i) begin
        d_gnt_c_o = 1'b1;
      end
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (i_gnt_c_o) begin
      starve_d = '0;
    end else if (i_req_i && !starved_c) begin
      starve_d = starve_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between the fetch and data ports,
// routing the 1-cycle read response back to the requester that was granted.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic                I_REQ,
  input  logic [31:0]         I_ADDR,
  output logic                I_GNT,
  output logic                I_RVALID,
  output logic [DATA_W-1:0]   I_RDATA,
  input  logic                D_REQ,
  input  logic                D_WE,
  input  logic [31:0]         D_ADDR,
  input  logic [DATA_W-1:0]   D_WDATA,
  input  logic [DATA_W/8-1:0] D_WMASK,
  output logic                D_GNT,
  output logic                D_RVALID,
  output logic [DATA_W-1:0]   D_RDATA,
  output logic                M_EN,
  output logic [ADDR_W-1:0]   M_ADDR,
  output logic [DATA_W/8-1:0] M_WE,
  output logic [DATA_W-1:0]   M_WDATA,
  input  logic [DATA_W-1:0]   M_RDATA
);

  own_e              owner_q;
  own_e              owner_d;
  logic [DATA_W-1:0] i_hold_q;
  logic [DATA_W-1:0] d_hold_q;

  // Byte-offset and above-RAM address bits are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{I_ADDR[31:ADDR_W+2], I_ADDR[1:0],
                              D_ADDR[31:ADDR_W+2], D_ADDR[1:0]};

  arb_starve_ctr #(
    .STARVE_MAX (STARVE_MAX)
  ) u_starve (
    .clk_i     (CLK),
    .rst_ni    (RESET_N),
    .i_req_i   (I_REQ),
    .d_req_i   (D_REQ),
    .i_gnt_c_o (I_GNT),
    .d_gnt_c_o (D_GNT)
  );

  // RAM command for the winning requester.
  always_comb begin
    M_EN    = I_GNT | D_GNT;
    M_ADDR  = '0;
    M_WE    = '0;
    M_WDATA = '0;
    if (I_GNT) begin
      M_ADDR = I_ADDR[ADDR_W+1:2];
    end else if (D_GNT) begin
      M_ADDR  = D_ADDR[ADDR_W+1:2];
      M_WDATA = D_WDATA;
      if (D_WE) begin
        M_WE = D_WMASK;
      end
    end
  end

  always_comb begin
    owner_d = OWN_NONE;
    if (I_GNT) begin
      owner_d = OWN_INSTR;
    end else if (D_GNT && !D_WE) begin
      owner_d = OWN_DATA;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      owner_q  <= OWN_NONE;
      i_hold_q <= '0;
      d_hold_q <= '0;
    end else begin
      owner_q <= owner_d;
      if (owner_q == OWN_INSTR) begin
        i_hold_q <= M_RDATA;
      end
      if (owner_q == OWN_DATA) begin
        d_hold_q <= M_RDATA;
      end
    end
  end

  // Live RAM data in the response cycle, last captured word otherwise.
  assign I_RVALID = (owner_q == OWN_INSTR);
  assign D_RVALID = (owner_q == OWN_DATA);
  assign I_RDATA  = I_RVALID ? M_RDATA : i_hold_q;
  assign D_RDATA  = D_RVALID ? M_RDATA : d_hold_q;

endmodule
